pipe_ctrl: RTL and testbench

//  Central stall/bubble controller for the 5-stage pipeline (pc, if_id, id_ex, ex_mem, mem_wb).

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_mc_timer.sv | 44 ++++
 rtl/pipe_ctrl.sv | 37 +++
 tb/tb_pipe_ctrl.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall bit indices, stall patterns and multi-cycle FSM states
package pipe_ctrl_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_MC_BUSY = 1'b1} state_t;
  localparam int STALL_PC = 0;
  localparam int STALL_IFID = 1;
  localparam int STALL_IDEX = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_MEMWB = 4;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU = 6'((1 << STALL_PC) | (1 << STALL_IFID));
  localparam logic [5:0] STALL_MC = STALL_LU | 6'(1 << STALL_IDEX);
  localparam logic [5:0] STALL_MEM = STALL_MC | 6'((1 << STALL_EXMEM) | (1 << STALL_MEMWB));
  function automatic logic reads(input logic rd, input logic [4:0] a, input logic [4:0] ex);
    return rd & (a == ex);
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs from ID/EX/MEM and stall/statistics outputs of the controller
interface pipe_ctrl_if #(parameter int MC_W = 6, parameter int PERF_W = 32);
  logic              id_reg_rd_1;
  logic              id_reg_rd_2;
  logic [4:0]        id_reg_addr_1;
  logic [4:0]        id_reg_addr_2;
  logic              ex_is_load;
  logic              ex_wd;
  logic [4:0]        ex_addr;
  logic              ex_mc_start;
  logic [MC_W-1:0]   ex_mc_cycles;
  logic              mem_stallreq;
  logic [5:0]        stall;
  logic              id_ex_flush;
  logic              mc_done;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] load_use_cnt;
  modport master(
    output id_reg_rd_1, id_reg_rd_2, id_reg_addr_1, id_reg_addr_2, ex_is_load, ex_wd, ex_addr,
           ex_mc_start, ex_mc_cycles, mem_stallreq,
    input  stall, id_ex_flush, mc_done, stall_cycles, load_use_cnt
  );
  modport slave(
    input  id_reg_rd_1, id_reg_rd_2, id_reg_addr_1, id_reg_addr_2, ex_is_load, ex_wd, ex_addr,
           ex_mc_start, ex_mc_cycles, mem_stallreq,
    output stall, id_ex_flush, mc_done, stall_cycles, load_use_cnt
  );
endinterface

// File: rtl/pipe_mc_timer.sv
// pipe_mc_timer: counts down a multi-cycle EX latency; busy while stalling, last while result is valid
module pipe_mc_timer
  import pipe_ctrl_pkg::*;
#(parameter int MC_W = 6) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [MC_W-1:0] n,
  input  logic            hold,
  output logic            busy,
  output logic            last
);
  localparam logic [MC_W-1:0] ONE = {{(MC_W-1){1'b0}}, 1'b1};
  state_t st, st_nx;
  logic [MC_W-1:0] cnt, cnt_nx;
  logic go;
  assign go = (st == ST_RUN) & start & (n > ONE);
  assign busy = go | ((st == ST_MC_BUSY) & (cnt > ONE));
  assign last = (st == ST_MC_BUSY) & (cnt == ONE);
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_RUN;
      cnt <= '0;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
    end
  end
  // the result slot stays at cnt==1 while MEM is waiting so mc_done is not lost
  always_comb begin
    st_nx = st;
    cnt_nx = cnt;
    if (go) begin
      st_nx = ST_MC_BUSY;
      cnt_nx = n - ONE;
    end else if (st == ST_MC_BUSY) begin
      if (cnt > ONE) cnt_nx = cnt - ONE;
      else if (!hold) begin
        st_nx = ST_RUN;
        cnt_nx = '0;
      end
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: load-use / multi-cycle / memory-wait stall controller with saturating statistics
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(parameter int MC_W = 6, parameter int PERF_W = 32) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave p
);
  logic lu, busy, last, flush_i;
  logic [5:0] stall_i;
  logic [PERF_W-1:0] sc, lc;
  pipe_mc_timer #(.MC_W(MC_W)) u_timer (
    .clk(clk), .rst(rst), .start(p.ex_mc_start), .n(p.ex_mc_cycles),
    .hold(p.mem_stallreq), .busy(busy), .last(last)
  );
  assign lu = p.ex_is_load & p.ex_wd & (|p.ex_addr) &
              (reads(p.id_reg_rd_1, p.id_reg_addr_1, p.ex_addr) |
               reads(p.id_reg_rd_2, p.id_reg_addr_2, p.ex_addr));
  always_comb begin
    stall_i = p.mem_stallreq ? STALL_MEM : busy ? STALL_MC : lu ? STALL_LU : STALL_NONE;
    flush_i = ~p.mem_stallreq & ~busy & lu;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sc <= '0;
      lc <= '0;
    end else begin
      if (stall_i[STALL_PC] & ~&sc) sc <= sc + 1'b1;
      if (flush_i & ~&lc) lc <= lc + 1'b1;
    end
  end
  assign p.stall = rst ? STALL_NONE : stall_i;
  assign p.id_ex_flush = ~rst & flush_i;
  assign p.mc_done = ~rst & last;
  assign p.stall_cycles = rst ? '0 : sc;
  assign p.load_use_cnt = rst ? '0 : lc;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus against a timestamp-based reference model
module tb_pipe_ctrl;
  localparam int MC_W = 6;
  localparam int PERF_W = 6;
  localparam int SAT = (1 << PERF_W) - 1;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pipe_ctrl_if #(.MC_W(MC_W), .PERF_W(PERF_W)) p();
  pipe_ctrl #(.MC_W(MC_W), .PERF_W(PERF_W)) dut (.clk(clk), .rst(rst), .p(p.slave));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, a, e);
    end
  endtask

  bit m_act = 0;
  int m_t0 = 0, m_n = 0, now = 0, m_sc = 0, m_lc = 0;
  always @(negedge clk) begin
    logic lu, dn, mcs, ef;
    logic [5:0] es;
    if (rst) begin
      chk("rst_stall", 32'(p.stall), 0);
      chk("rst_flush", 32'(p.id_ex_flush), 0);
      chk("rst_done", 32'(p.mc_done), 0);
      chk("rst_sc", 32'(p.stall_cycles), 0);
      chk("rst_lc", 32'(p.load_use_cnt), 0);
      m_act = 0;
      m_sc = 0;
      m_lc = 0;
    end else begin
      lu = p.ex_is_load && p.ex_wd && p.ex_addr != 0 &&
           ((p.id_reg_rd_1 && p.id_reg_addr_1 == p.ex_addr) ||
            (p.id_reg_rd_2 && p.id_reg_addr_2 == p.ex_addr));
      dn = m_act && (now - m_t0 >= m_n - 1);
      mcs = m_act ? !dn : (p.ex_mc_start && p.ex_mc_cycles >= 2);
      es = p.mem_stallreq ? 6'b011111 : mcs ? 6'b000111 : lu ? 6'b000011 : 6'b000000;
      ef = !p.mem_stallreq && !mcs && lu;
      chk("stall", 32'(p.stall), 32'(es));
      chk("flush", 32'(p.id_ex_flush), 32'(ef));
      chk("mc_done", 32'(p.mc_done), 32'(dn));
      chk("stall_cycles", 32'(p.stall_cycles), m_sc);
      chk("load_use_cnt", 32'(p.load_use_cnt), m_lc);
      if (es[0] && m_sc < SAT) m_sc++;
      if (ef && m_lc < SAT) m_lc++;
      if (!m_act && mcs) begin
        m_act = 1;
        m_t0 = now;
        m_n = int'(p.ex_mc_cycles);
      end else if (dn && !p.mem_stallreq) m_act = 0;
    end
    now++;
  end

  task automatic idle();
    p.id_reg_rd_1 = 0; p.id_reg_rd_2 = 0; p.id_reg_addr_1 = 0; p.id_reg_addr_2 = 0;
    p.ex_is_load = 0; p.ex_wd = 0; p.ex_addr = 0; p.ex_mc_start = 0; p.ex_mc_cycles = 0;
    p.mem_stallreq = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_lu(input logic [4:0] ea, input logic rd1);
    p.ex_is_load = 1; p.ex_wd = 1; p.ex_addr = ea; p.id_reg_rd_1 = rd1; p.id_reg_addr_1 = 5;
  endtask
  task automatic set_mc(input int n, input logic mem);
    idle();
    p.ex_mc_start = 1; p.ex_mc_cycles = MC_W'(n); p.mem_stallreq = mem;
  endtask

  initial begin
    idle();
    step(); #2;
    chk("t0_rst_stall", 32'(p.stall), 0);
    step(); rst = 0; set_lu(5, 1); #2;
    chk("t1_stall", 32'(p.stall), 32'h03);
    chk("t1_flush", 32'(p.id_ex_flush), 1);
    step(); idle(); #2;
    chk("t1_cnt", 32'(p.load_use_cnt), 1);
    chk("t1_after", 32'(p.stall), 0);
    step(); set_lu(0, 1); p.id_reg_addr_1 = 0; #2;
    chk("t2_zero", 32'(p.stall), 0);
    step(); idle(); set_lu(5, 0); #2;
    chk("t2_nord", 32'(p.id_ex_flush), 0);
    for (int c = 0; c < 5; c++) begin
      step(); if (c < 4) set_mc(4, 0); else idle(); #2;
      chk("t3_stall", 32'(p.stall), c < 3 ? 32'h07 : 0);
      chk("t3_done", 32'(p.mc_done), c == 3 ? 1 : 0);
    end
    chk("t3_sc", 32'(p.stall_cycles), 4);
    for (int c = 0; c < 7; c++) begin
      step(); if (c < 6) set_mc(4, c >= 2 && c <= 4); else idle(); #2;
      chk("t4_stall", 32'(p.stall), (c >= 2 && c <= 4) ? 32'h1f : c < 2 ? 32'h07 : 0);
      chk("t4_done", 32'(p.mc_done), (c >= 3 && c <= 5) ? 1 : 0);
    end
    chk("t4_sc", 32'(p.stall_cycles), 9);
    step(); idle(); set_lu(5, 1); p.mem_stallreq = 1; #2;
    chk("t5_stall", 32'(p.stall), 32'h1f);
    chk("t5_flush", 32'(p.id_ex_flush), 0);
    step(); p.mem_stallreq = 0; #2;
    chk("t5_rel", 32'(p.id_ex_flush), 1);
    step(); idle(); #2;
    chk("t5_cnt", 32'(p.load_use_cnt), 2);
    for (int c = 0; c < 5; c++) begin step(); set_mc(8, 0); end
    step(); rst = 1; #2;
    chk("t6_stall", 32'(p.stall), 0);
    chk("t6_sc", 32'(p.stall_cycles), 0);
    step(); rst = 0; idle(); #2;
    chk("t6_run", 32'(p.stall), 0);
    chk("t6_done", 32'(p.mc_done), 0);
    chk("t6_sc0", 32'(p.stall_cycles), 0);
    for (int c = 0; c < 70; c++) begin step(); idle(); set_lu(5, 1); end
    step(); idle(); #2;
    chk("sat_sc", 32'(p.stall_cycles), SAT);
    chk("sat_lc", 32'(p.load_use_cnt), SAT);
    step(); p.mem_stallreq = 1; step(); #2;
    chk("sat_hold", 32'(p.stall_cycles), SAT);
    for (int c = 0; c < 4000; c++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      p.id_reg_rd_1 = 1'($urandom);
      p.id_reg_rd_2 = 1'($urandom);
      p.id_reg_addr_1 = 5'($urandom_range(0, 3));
      p.id_reg_addr_2 = 5'($urandom_range(0, 3));
      p.ex_is_load = 1'($urandom);
      p.ex_wd = ($urandom_range(0, 3) != 0);
      p.ex_addr = 5'($urandom_range(0, 3));
      p.ex_mc_start = ($urandom_range(0, 3) == 0);
      p.ex_mc_cycles = ($urandom_range(0, 15) == 0) ? MC_W'($urandom) : MC_W'($urandom_range(0, 6));
      p.mem_stallreq = ($urandom_range(0, 4) == 0);
    end
    step(); idle(); rst = 0;
    step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
